vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 sync block.
- Generates hsync, vsync, video_on and pixel coordinates for any mode set by parameters, with a configurable pixel-clock divider and sync polarity.
- Adds a run enable and line/frame strobes, plus a frame counter, for pixel generators and frame-synchronous logic.
- Sits between the system clock and the pixel/colour pipeline that drives the VGA connector.

Parameters:
- CNT_W, 10, width of the h/v counters and pixel_x/pixel_y; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level (0 = active-low).
- DIV, 2, clk cycles per pixel (>=1); DIV_W = max(1, clog2(DIV)).
- FRAME_W, 16, frame counter width.
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run request; low holds the raster idle at (0,0)
- p_tick  out  1  pixel enable, one clk wide, every DIV clks while running
- pixel_x  out  CNT_W  current h count
- pixel_y  out  CNT_W  current v count
- hsync  out  1  registered horizontal sync, polarity H_POL
- vsync  out  1  registered vertical sync, polarity V_POL
- video_on  out  1  registered; high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- line_end  out  1  one-clk strobe on the last pixel tick of each line
- frame_end  out  1  one-clk strobe on the last pixel tick of each frame
- frame_cnt  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W

Behaviour:
- Reset values: run=0, div_cnt=0, h_cnt=0, v_cnt=0, frame_cnt=0, video_on=0.
- Sync outputs reset to inactive: hsync=~H_POL, vsync=~V_POL.
- run register: run <= enable each clk.
- While run=0: div_cnt, h_cnt and v_cnt are forced to 0; p_tick=0; strobes=0; hsync/vsync inactive; video_on=0; frame_cnt holds.
- Divider: div_cnt counts 0..DIV-1 while run=1.
- p_tick = run & (div_cnt==DIV-1). For DIV=1, p_tick = run.
- h_cnt: advances only on clk edges where p_tick=1. Wraps from H_TOTAL-1 to 0.
- v_cnt: advances only when p_tick=1 and h_cnt==H_TOTAL-1. Wraps from V_TOTAL-1 to 0.
- Line order: active, front porch, sync, back porch.
- hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Output invariant, every clk: hsync, vsync and video_on equal (run ? decode(current h_cnt, v_cnt) : inactive). Registers are loaded from next-state counts and next run, so there is no lag versus pixel_x/pixel_y and no glitches.
- pixel_x = h_cnt, pixel_y = v_cnt, combinational from the registers.
- line_end = p_tick & (h_cnt==H_TOTAL-1).
- frame_end = line_end & (v_cnt==V_TOTAL-1).
- frame_cnt increments on the clk edge where frame_end=1.
- enable rising: counters start from (0,0). The first clk with run=1 shows video_on=1 (when H_ACTIVE, V_ACTIVE > 0). The first p_tick occurs DIV clks after run rises.
- enable falling mid-frame: on the next edge run=0, counters go to 0 and outputs go inactive. frame_cnt is not changed; the partial frame is not counted.
- reset mid-frame: all registers return to reset values immediately (asynchronous).

Test Plan:
- Defaults, enable=1 after reset -> p_tick every 2nd clk; line_end period 1600 clk; frame_end period 840000 clk; frame_cnt=1 after first frame_end.
- Defaults, line 0 -> video_on high for h 0..639; hsync low exactly for h 656..751; vsync low exactly for lines 490..491; video_on low on lines 480..524.
- H_POL=1, V_POL=1, DIV=1, small mode (H 8/2/3/1, V 4/1/1/1) -> hsync high for h 10..12; vsync high on line 5; H_TOTAL=14, V_TOTAL=7; p_tick constant 1.
- Drop enable at (h=300, v=200), restart 5 clk later -> outputs inactive and counts 0 during idle; frame_cnt unchanged; restart at (0,0) with video_on=1 on the first run cycle.
- FRAME_W=2, small mode -> frame_cnt sequence 1,2,3,0 over 4 frames.
- Assert reset mid-line with DIV=3 -> all outputs at reset values in the same cycle; after release, first p_tick 3 clk after run rises.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, h/v counters,
// registered sync/blanking decode, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int   CNT_W    = 10,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   DIV      = 2,
  parameter int   FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               p_tick,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_end,
  output logic               frame_end,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               r_run;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [CNT_W-1:0]   r_h_cnt;
  logic [CNT_W-1:0]   r_v_cnt;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_video_on;

  logic               w_div_last;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_p_tick;
  logic               w_line_end;
  logic               w_frame_end;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [CNT_W-1:0]   w_h_nxt;
  logic [CNT_W-1:0]   w_v_nxt;
  logic               w_hsync_nxt;
  logic               w_vsync_nxt;
  logic               w_video_nxt;

  assign w_div_last  = (r_div_cnt == DIV_LAST);
  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_p_tick    = r_run & w_div_last;
  assign w_line_end  = w_p_tick & w_h_last;
  assign w_frame_end = w_line_end & w_v_last;

  // Next-state counts; a low enable (or the idle cycle before run rises)
  // parks the raster at (0,0) so a restart always begins a fresh frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_div_nxt = '0;
    w_h_nxt   = '0;
    w_v_nxt   = '0;
    if (enable && r_run) begin
      w_div_nxt = w_div_last ? '0 : r_div_cnt + 1'b1;
      w_h_nxt   = r_h_cnt;
      w_v_nxt   = r_v_cnt;
      if (w_p_tick) begin
        w_h_nxt = w_h_last ? '0 : r_h_cnt + 1'b1;
        if (w_h_last) w_v_nxt = w_v_last ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  // Decoding the next counts lets the registered syncs line up with pixel_x/y.
  always_comb begin
    w_hsync_nxt = ~H_POL;
    w_vsync_nxt = ~V_POL;
    w_video_nxt = 1'b0;
    if (enable) begin
      if ((w_h_nxt >= H_SYNC_START) && (w_h_nxt < H_SYNC_END)) w_hsync_nxt = H_POL;
      if ((w_v_nxt >= V_SYNC_START) && (w_v_nxt < V_SYNC_END)) w_vsync_nxt = V_POL;
      w_video_nxt = (w_h_nxt < H_ACT_C) && (w_v_nxt < V_ACT_C);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run       <= 1'b0;
      r_div_cnt   <= '0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
      r_hsync     <= ~H_POL;
      r_vsync     <= ~V_POL;
      r_video_on  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_run      <= enable;
      r_div_cnt  <= w_div_nxt;
      r_h_cnt    <= w_h_nxt;
      r_v_cnt    <= w_v_nxt;
      r_hsync    <= w_hsync_nxt;
      r_vsync    <= w_vsync_nxt;
      r_video_on <= w_video_nxt;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign p_tick    = w_p_tick;
  assign pixel_x   = r_h_cnt;
  assign pixel_y   = r_v_cnt;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = r_video_on;
  assign line_end  = w_line_end;
  assign frame_end = w_frame_end;
  assign frame_cnt = r_frame_cnt;

endmodule
